fpu_result_stage: RTL and testbench

// - Output stage after the FP add/sub exception logic. Takes the raw result
//   (sign, exponent_z, Mz) and the invalid/overflow/zero flags, and substitutes

---
 rtl/fpu_result_stage.sv | 152 +++++++++++++++
 tb/tb_fpu_result_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_stage.sv
// rtl/fpu_result_stage.sv - FP add/sub result fix-up, output FIFO, sticky status and op counter
//
// Substitutes IEEE-754 special encodings (qNaN, +/-inf, +/-0) according to the
// exception flags, buffers the fixed-up result plus its raw flags in a small
// FIFO, accumulates sticky status flags and counts completed output handshakes.
//
// Optional feature macro: FPU_STATUS_IRQ_EN (adds irq_mask / irq ports).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             upstream handshake (in_ready = !full)
//   in_sign, in_exp, in_mant        raw result fields
//   invalid_flag, overflow_flag,
//   zero_flag                       exception flags for the raw result
//   out_valid / out_ready           downstream handshake on the FIFO head
//   out_result, out_flags           head result and its {invalid,overflow,zero}
//   sticky_flags, clr_sticky        accumulated flags and their clear pulse
//   op_count                        saturating count of output handshakes
//   irq_mask, irq                   (FPU_STATUS_IRQ_EN only) masked sticky interrupt

module fpu_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_exp,
  input  logic [22:0]      in_mant,
  input  logic             invalid_flag,
  input  logic             overflow_flag,
  input  logic             zero_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags,
  output logic [2:0]       sticky_flags,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
`ifdef FPU_STATUS_IRQ_EN
  ,
  input  logic [2:0]       irq_mask,
  output logic             irq
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Each entry: {flags[2:0], result[31:0]}
  logic [34:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [2:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [31:0] fix_result;
  logic [2:0]  in_flags;
  logic        push, pop;

  // in_ready depends on registered occupancy only, so a pop while full
  // re-opens the input one cycle later.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_flags  = {invalid_flag, overflow_flag, zero_flag};

  // Special-encoding substitution, highest priority first.
  always_comb begin
    fix_result = {in_sign, in_exp, in_mant};
    if (invalid_flag) begin
      fix_result = 32'h7FC0_0000;
    end else if (overflow_flag) begin
      fix_result = {in_sign, 8'hFF, 23'h0};
    end else if (zero_flag) begin
      fix_result = {in_sign, 31'h0};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A push in the same cycle as clr_sticky keeps the pushed flags.
  always_comb begin
    sticky_d = clr_sticky ? 3'b000 : sticky_q;
    if (push) begin
      sticky_d = sticky_d | in_flags;
    end
  end

  always_comb begin
    op_count_d = op_count_q;
    if (pop && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_q   <= '0;
      op_count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {in_flags, fix_result};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  // Head is masked when empty so stale entries never appear on the output.
  assign out_result   = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign out_flags    = out_valid ? mem_q[rd_ptr_q][34:32] : 3'b000;
  assign sticky_flags = sticky_q;
  assign op_count     = op_count_q;

`ifdef FPU_STATUS_IRQ_EN
  logic irq_q;

  // Uses next-state sticky so irq rises together with the flag it reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(sticky_d & irq_mask);
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
// tb/tb_fpu_result_stage.sv - directed table-driven bench for fpu_result_stage

module tb_fpu_result_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [7:0]       in_exp;
  logic [22:0]      in_mant;
  logic             invalid_flag, overflow_flag, zero_flag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;
  logic [2:0]       sticky_flags;
  logic             clr_sticky;
  logic [CNT_W-1:0] op_count;
`ifdef FPU_STATUS_IRQ_EN
  logic [2:0]       irq_mask;
  logic             irq;
`endif

  fpu_result_stage #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .invalid_flag (invalid_flag),
    .overflow_flag(overflow_flag),
    .zero_flag    (zero_flag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .op_count     (op_count)
`ifdef FPU_STATUS_IRQ_EN
    ,
    .irq_mask     (irq_mask),
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic [2:0]  flags;   // {invalid, overflow, zero}
    logic [31:0] result;
  } vec_t;

  vec_t vecs [7];
  int tests = 0;
  int fails = 0;
  int exp_cnt;
  logic [2:0] exp_sticky;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic [2:0] f);
    in_valid      = v;
    in_sign       = s;
    in_exp        = e;
    in_mant       = m;
    invalid_flag  = f[2];
    overflow_flag = f[1];
    zero_flag     = f[0];
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h80, 23'h000001, 3'b000, 32'h4000_0001};
    vecs[1] = '{1'b1, 8'h12, 23'h000055, 3'b110, 32'h7FC0_0000};
    vecs[2] = '{1'b1, 8'h40, 23'h000123, 3'b010, 32'hFF80_0000};
    vecs[3] = '{1'b0, 8'h05, 23'h000003, 3'b001, 32'h0000_0000};
    vecs[4] = '{1'b1, 8'h33, 23'h0000AA, 3'b001, 32'h8000_0000};
    vecs[5] = '{1'b1, 8'hFF, 23'h7FFFFF, 3'b111, 32'h7FC0_0000};
    vecs[6] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b000, 32'hFF7F_FFFF};

    rst_n = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
`ifdef FPU_STATUS_IRQ_EN
    irq_mask = 3'b000;
`endif
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
`ifdef FPU_STATUS_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Fix-up table at full throughput: each head is popped on the next push edge.
    out_ready = 1'b1;
    exp_cnt = 0;
    exp_sticky = 3'b000;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].sign, vecs[i].exp, vecs[i].mant, vecs[i].flags);
      tick();
      exp_sticky = exp_sticky | vecs[i].flags;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_result", i), out_result, vecs[i].result);
      check($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags));
      check($sformatf("vec%0d_sticky", i), 32'(sticky_flags), 32'(exp_sticky));
      check($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(exp_cnt));
      exp_cnt++;
    end
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_op_count", 32'(op_count), 32'(exp_cnt));

    // Sticky clear alone, then clear together with an overflow push.
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("clr_sticky", 32'(sticky_flags), 32'd0);
    drive(1'b1, 1'b0, 8'h00, 23'h0, 3'b001);
    tick();
    check("zero_push_result", out_result, 32'h0);
    check("zero_push_sticky", 32'(sticky_flags), 32'd1);
    drive(1'b1, 1'b1, 8'h20, 23'h1, 3'b010);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    exp_cnt++;
    check("clr_push_result", out_result, 32'hFF80_0000);
    check("clr_push_flags", 32'(out_flags), 32'd2);
    check("clr_push_sticky", 32'(sticky_flags), 32'd2);
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
    tick();
    exp_cnt++;
    check("clr_drain_count", 32'(op_count), 32'(exp_cnt));

    // Fill with out_ready low; third op refused, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h7F, 23'h0, 3'b000);
    tick();
    check("fill1_ready", 32'(in_ready), 32'd1);
    check("fill1_head", out_result, 32'h3F80_0000);
    drive(1'b1, 1'b1, 8'h81, 23'h400000, 3'b000);
    tick();
    check("fill2_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b0, 8'h82, 23'h200000, 3'b000);
    tick();
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_head_stable", out_result, 32'h3F80_0000);
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    check("pop1_ready_reopen", 32'(in_ready), 32'd1);
    check("pop1_head", out_result, 32'hC0C0_0000);
    check("pop1_count", 32'(op_count), 32'(exp_cnt));
    tick();
    exp_cnt++;
    check("pop2_head", out_result, 32'h4120_0000);
    check("pop2_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
    tick();
    exp_cnt++;
    check("pop3_valid", 32'(out_valid), 32'd0);
    check("pop3_count", 32'(op_count), 32'(exp_cnt));

    // op_count saturation (CNT_W=4): 12 so far, continuous stream.
    drive(1'b1, 1'b0, 8'h80, 23'h1, 3'b000);
    repeat (3) tick();
    check("sat_pre", 32'(op_count), 32'd14);
    repeat (3) tick();
    check("sat_hold", 32'(op_count), 32'hF);
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
    tick();
    check("sat_hold2", 32'(op_count), 32'hF);
    check("sat_empty", 32'(out_valid), 32'd0);

`ifdef FPU_STATUS_IRQ_EN
    irq_mask = 3'b100;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("irq_cleared", 32'(irq), 32'd0);
    drive(1'b1, 1'b0, 8'h10, 23'h0, 3'b010);
    tick();
    check("irq_masked_ovf", 32'(irq), 32'd0);
    drive(1'b1, 1'b0, 8'h10, 23'h0, 3'b100);
    tick();
    check("irq_invalid", 32'(irq), 32'd1);
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
    irq_mask = 3'b000;
    tick();
    check("irq_mask_off", 32'(irq), 32'd0);
    irq_mask = 3'b100;
    tick();
    check("irq_mask_on", 32'(irq), 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("irq_clr", 32'(irq), 32'd0);
    check("irq_clr_sticky", 32'(sticky_flags), 32'd0);
`endif

    // Asynchronous reset with two entries queued.
    tick();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h12, 23'h55, 3'b110);
    tick();
    drive(1'b1, 1'b0, 8'h80, 23'h1, 3'b000);
    tick();
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
    check("prerst_valid", 32'(out_valid), 32'd1);
    check("prerst_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_sticky", 32'(sticky_flags), 32'd0);
    check("arst_count", 32'(op_count), 32'd0);
    check("arst_result", out_result, 32'h0);
`ifdef FPU_STATUS_IRQ_EN
    check("arst_irq", 32'(irq), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postrst_empty", 32'(out_valid), 32'd0);
    drive(1'b1, vecs[6].sign, vecs[6].exp, vecs[6].mant, vecs[6].flags);
    tick();
    drive(1'b0, 1'b0, 8'h0, 23'h0, 3'b000);
    check("postrst_valid", 32'(out_valid), 32'd1);
    check("postrst_head", out_result, 32'hFF7F_FFFF);
    check("postrst_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
